// File: rtl/pRISC_pkg.sv
// pRISC shared definitions: register file geometry defaults, clear-controller
// state encoding and the hardwired zero register index.
package pRISC_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   // Register index that is hardwired to zero.
   localparam int REG_ZERO = 0;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear controller for the pRISC register file. After reset it walks every
// entry once, emitting a zero-write per cycle, then parks in RUN until the
// next reset.
module rf_clear_ctrl
   import pRISC_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clear_we,
   output logic [ADDR_W-1:0] clear_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   rf_state_t         state;
   logic [ADDR_W-1:0] clr_idx;

   // State, index counter and busy flag; busy drops on the edge that clears the last entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            RF_CLEAR: begin
               clr_idx <= clr_idx + ADDR_W'(1);
               if (clr_idx == LAST_IDX) begin
                  state <= RF_RUN;
                  busy  <= 1'b0;
               end
            end
            RF_RUN: begin
               busy <= 1'b0;
            end
            default: begin
               state   <= RF_CLEAR;
               clr_idx <= '0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

   assign clear_we   = (state == RF_CLEAR);
   assign clear_addr = clr_idx;

endmodule

// File: rtl/reg_file_2r1w.sv
// pRISC register file: two registered read ports, one write port, entry 0
// hardwired to zero, zeroed by a clear sequence after every reset.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on a
// same-cycle write/read of one address; otherwise reads return the old value.
module reg_file_2r1w
   import pRISC_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re_a,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int                DEPTH  = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clear_we;
   logic [ADDR_W-1:0] clear_addr;
   logic              wr_en;
   logic              byp_a, byp_b;
   logic [DATA_W-1:0] rd_a, rd_b;

   rf_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
      .clk        (clk),
      .rst        (rst),
      .busy       (busy),
      .clear_we   (clear_we),
      .clear_addr (clear_addr)
   );

   // Functional writes only outside the clear sequence, never to the zero register.
   assign wr_en = !clear_we && we && (waddr != ZERO_A);

`ifdef REGFILE_BYPASS_EN
   assign byp_a = wr_en && (waddr == raddr_a);
   assign byp_b = wr_en && (waddr == raddr_b);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   // Read-data select: zero register, forwarded write data, or stored entry.
   always_comb begin
      rd_a = mem[raddr_a];
      rd_b = mem[raddr_b];
      if (byp_a)              rd_a = wdata;
      if (byp_b)              rd_b = wdata;
      if (raddr_a == ZERO_A)  rd_a = '0;
      if (raddr_b == ZERO_A)  rd_b = '0;
   end

   // Storage array; a write coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clear_we)
            mem[clear_addr] <= '0;
         else if (wr_en)
            mem[waddr] <= wdata;
      end
   end

   // Registered read ports: zero during reset/clear, hold when not enabled.
   always_ff @(posedge clk) begin
      if (rst || clear_we) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (re_a) rdata_a <= rd_a;
         if (re_b) rdata_b <= rd_b;
      end
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus random
// traffic, all checked against a behavioural register-file model.
module tb_reg_file_2r1w;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          busy;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re_a;
   logic [AW-1:0] raddr_a;
   logic [DW-1:0] rdata_a;
   logic          re_b;
   logic [AW-1:0] raddr_b;
   logic [DW-1:0] rdata_b;

   always #5 clk = ~clk;

   reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .re_a    (re_a),
      .raddr_a (raddr_a),
      .rdata_a (rdata_a),
      .re_b    (re_b),
      .raddr_b (raddr_b),
      .rdata_b (rdata_b)
   );

   // Reference model: architectural register contents, cycles of clearing
   // still to go, and the value each read port should be showing.
   logic [DW-1:0] mm [DEPTH];
   int            left;
   logic [DW-1:0] ea, eb;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = mm[a];
`ifdef REGFILE_BYPASS_EN
      if (we && waddr == a) v = wdata;
`endif
      if (a == 0) v = '0;
      return v;
   endfunction

   // Advance the model by one edge using the inputs currently applied,
   // then clock the DUT and compare.
   task automatic tick(input string tag);
      if (rst) begin
         left = DEPTH;
         ea   = '0;
         eb   = '0;
         for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end else if (left > 0) begin
         left--;
         ea = '0;
         eb = '0;
      end else begin
         if (re_a) ea = model_rd(raddr_a);
         if (re_b) eb = model_rd(raddr_b);
         if (we && waddr != 0) mm[waddr] = wdata;
      end
      @(posedge clk);
      #1;
      chk({tag, "_busy"}, DW'(busy), DW'(left > 0 ? 1 : 0));
      chk({tag, "_rda"}, rdata_a, ea);
      chk({tag, "_rdb"}, rdata_b, eb);
   endtask

   task automatic idle();
      we = 1'b0; re_a = 1'b0; re_b = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle();
      we = 1'b1; waddr = a; wdata = d;
      tick("wr");
   endtask

   task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b);
      idle();
      re_a = 1'b1; raddr_a = a;
      re_b = 1'b1; raddr_b = b;
      tick("rd");
   endtask

   // Reset pulse, then count busy cycles while hammering r9 with writes.
   task automatic do_reset();
      int cnt;
      idle();
      rst = 1'b1;
      tick("rst");
      rst = 1'b0;
      cnt = (busy === 1'b1) ? 1 : 0;
      we = 1'b1; waddr = 5'd9;
      for (int i = 0; i < 100; i++) begin
         wdata = $urandom;
         tick("clr");
         if (busy !== 1'b1) break;
         cnt++;
      end
      idle();
      chk("busy_len", DW'(cnt), DW'(32));
   endtask

   initial begin
      rst = 1'b1; left = 0; ea = '0; eb = '0;
      waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      idle();
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;

      // Reset and clear wipe a previously written entry.
      do_reset();
      wr(5'd7, 32'hDEADBEEF);
      rd2(5'd7, 5'd7);
      chk("r7_written", rdata_a, 32'hDEADBEEF);
      do_reset();
      rd2(5'd7, 5'd0);
      chk("r7_cleared", rdata_a, 32'h0);

      // Basic write/read on both ports.
      wr(5'd3, 32'h12345678);
      wr(5'd4, 32'h0000FFFF);
      rd2(5'd3, 5'd4);
      chk("r3", rdata_a, 32'h12345678);
      chk("r4", rdata_b, 32'h0000FFFF);

      // Zero register ignores writes.
      wr(5'd0, 32'hFFFFFFFF);
      rd2(5'd0, 5'd0);
      chk("r0_a", rdata_a, 32'h0);
      chk("r0_b", rdata_b, 32'h0);

      // Same address on both ports.
      rd2(5'd3, 5'd3);
      chk("same_a", rdata_a, 32'h12345678);
      chk("same_b", rdata_b, 32'h12345678);

      // Same-cycle write/read collision.
      wr(5'd5, 32'h11);
      idle();
      we = 1'b1; waddr = 5'd5; wdata = 32'h22;
      re_a = 1'b1; raddr_a = 5'd5;
      tick("coll");
`ifdef REGFILE_BYPASS_EN
      chk("coll_rd", rdata_a, 32'h22);
`else
      chk("coll_rd", rdata_a, 32'h11);
`endif
      rd2(5'd5, 5'd5);
      chk("coll_next", rdata_a, 32'h22);

      // Reset in the middle of a clear restarts the full sequence.
      wr(5'd9, 32'h99);
      idle();
      rst = 1'b1;
      tick("rst_mid");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick("clr10");
      do_reset();
      rd2(5'd9, 5'd9);
      chk("r9_lost", rdata_a, 32'h0);

      // Read hold while re_a is low.
      wr(5'd6, 32'h66);
      rd2(5'd6, 5'd6);
      idle();
      raddr_a = 5'd8; we = 1'b1; waddr = 5'd6; wdata = 32'h77;
      tick("hold1");
      chk("hold1", rdata_a, 32'h66);
      idle();
      raddr_a = 5'd6;
      tick("hold2");
      chk("hold2", rdata_a, 32'h66);
      rd2(5'd6, 5'd8);
      chk("hold_rel", rdata_a, 32'h77);

      // Random traffic with occasional resets; small address range forces collisions.
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 199) == 0);
         we      = $urandom_range(0, 1) == 1;
         waddr   = AW'($urandom_range(0, 7));
         wdata   = $urandom;
         re_a    = $urandom_range(0, 3) != 0;
         raddr_a = AW'($urandom_range(0, 7));
         re_b    = $urandom_range(0, 3) != 0;
         raddr_b = AW'($urandom_range(0, 7));
         tick("rnd");
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Register file for the pRISC datapath: 2 synchronous read ports, 1 synchronous write port.
- Sits between decode (reads) and writeback (writes); it is the storage/read side that the writeback stage writes into.
- After reset, a counter-driven clear sequence zeroes every entry; busy is asserted for the whole sequence.

Parameters:
- DATA_W, 32, width of each register in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- busy  output  1  high while the clear sequence runs
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  DATA_W  registered read data, port A
- re_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  DATA_W  registered read data, port B

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=CLEAR, clr_idx=0, busy=1, rdata_a=0, rdata_b=0.
- State CLEAR:
  - Each cycle writes 0 to entry clr_idx, then clr_idx++.
  - When clr_idx == 2**ADDR_W-1, that entry is cleared and state goes to RUN in the same edge.
  - The sequence takes exactly 2**ADDR_W cycles (32 by default); busy falls on the edge that ends it.
  - we, re_a and re_b are ignored; rdata_a and rdata_b hold 0.
- State RUN:
  - busy=0.
  - Write: if we=1 and waddr!=0, mem[waddr] <= wdata at the edge.
  - Read: if re_x=1, rdata_x <= mem[raddr_x] at the edge (latency 1 cycle).
  - If re_x=0, rdata_x holds its previous value.
- Entry 0 always reads as 0; writes to address 0 are dropped.
- Both ports may read the same address in the same cycle; each returns the same data.
- Same-cycle write and read to the same nonzero address: result is set by the optional feature below.
- rst asserted in any state, including mid-CLEAR or mid-RUN:
  - The next edge restarts CLEAR at clr_idx=0 and zeroes rdata_a/rdata_b.
  - A write presented in that same cycle is discarded.
- RUN has no exit other than rst.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first bypass):
  - When re_x=1, we=1, waddr==raddr_x and waddr!=0, rdata_x <= wdata.
  - Gives writeback-to-decode forwarding with no extra pipeline logic.
- Undefined (read-first):
  - rdata_x <= the old mem[raddr_x] value.
  - The new value is visible from the following read onward.

Decomposition:
- Shared package pRISC_pkg:
  - DATA_W/ADDR_W defaults.
  - State encoding constants RF_CLEAR=1'b0, RF_RUN=1'b1.
  - Constant REG_ZERO=0.
- Natural sub-module: rf_clear_ctrl.
  - Contains the state register, clr_idx counter and busy.
  - Outputs clear_we and clear_addr to the storage array.
- Array and read/bypass muxes stay in the top module.

Test Plan:
- Reset and clear:
  - Write 0xDEADBEEF to r7, then pulse rst.
  - Expect busy=1 for exactly 32 cycles, then busy=0.
  - Then read r7 -> rdata_a=0.
- Basic write/read:
  - Write r3=0x12345678 and r4=0x0000FFFF.
  - Next cycle, raddr_a=3, raddr_b=4.
  - One cycle later, expect rdata_a=0x12345678, rdata_b=0x0000FFFF.
- Zero register:
  - Write r0=0xFFFFFFFF, then read r0 on both ports -> expect 0 on both.
- Same-cycle collision:
  - r5 holds 0x11. In one cycle, write r5=0x22 and read r5.
  - With REGFILE_BYPASS_EN -> rdata_a=0x22.
  - Without it -> rdata_a=0x11, and the next read returns 0x22.
- Reset mid-clear:
  - Assert rst at clear cycle 10 -> clr_idx restarts.
  - busy stays high for another full 32 cycles from the new reset edge.
  - A write attempted during busy is lost: reading that address gives 0.
- Read hold:
  - With re_a=0, change raddr_a and write to the old address.
  - rdata_a must keep its prior value until re_a returns to 1.
